parity_arb_ctrl: RTL and testbench

PARITY_ARB_CTRL -- requirements
Module: parity_arb_ctrl

---
 rtl/parity_pkg.sv | 22 ++
 rtl/even_parity_unit.sv | 11 +
 rtl/parity_arb_ctrl.sv | 122 ++++++++++++
 tb/tb_parity_arb_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared types and constants for the parity request arbiter.
// Holds the FSM encoding, source ids and the round-robin pick helper.
package parity_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StResp = 2'd2
    } state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // When both requesters are valid the one not granted last time wins.
    function automatic logic rr_pick(input logic a_v, input logic b_v, input logic last_src);
        if (a_v && b_v) begin
            return ~last_src;
        end
        return b_v ? SRC_B : SRC_A;
    endfunction

endpackage

// File: rtl/even_parity_unit.sv
// Combinational even-parity generator: XOR-reduce of the data word.
module even_parity_unit #(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    output logic              par
);

    assign par = ^data;

endmodule

// File: rtl/parity_arb_ctrl.sv
// Two-requester round-robin front end for a shared even-parity unit.
// A asks for parity generation, B asks for a parity check; one request in flight at a time.
module parity_arb_ctrl
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_par,
    output logic              b_ready,
    output logic              out_valid,
    output logic              out_src,
    output logic [DATA_W-1:0] out_data,
    output logic              out_par,
    output logic              out_err,
    input  logic              out_ready,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax = '1;

    state_t            state_q;
    logic              last_src_q;
    logic              cap_src_q;
    logic [DATA_W-1:0] cap_data_q;
    logic              cap_par_q;

    logic              grant_src;
    logic              idle;
    logic              hs;
    logic              calc_par;
    logic              resp_acc;

    even_parity_unit #(
        .DATA_W(DATA_W)
    ) u_par (
        .data(cap_data_q),
        .par (calc_par)
    );

    assign idle      = (state_q == StIdle);
    assign grant_src = rr_pick(a_valid, b_valid, last_src_q);

    // Ready is gated by rst so no handshake can be seen while reset is held.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (idle && !rst) begin
            a_ready = a_valid && (grant_src == SRC_A);
            b_ready = b_valid && (grant_src == SRC_B);
        end
    end

    assign hs       = (a_valid && a_ready) || (b_valid && b_ready);
    assign resp_acc = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            last_src_q <= SRC_B;
            cap_src_q  <= SRC_A;
            cap_data_q <= '0;
            cap_par_q  <= 1'b0;
            out_valid  <= 1'b0;
            out_src    <= SRC_A;
            out_data   <= '0;
            out_par    <= 1'b0;
            out_err    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (hs) begin
                        cap_src_q  <= grant_src;
                        cap_data_q <= (grant_src == SRC_B) ? b_data : a_data;
                        cap_par_q  <= (grant_src == SRC_B) ? b_par : 1'b0;
                        last_src_q <= grant_src;
                        state_q    <= StCalc;
                    end
                end
                StCalc: begin
                    out_valid <= 1'b1;
                    out_src   <= cap_src_q;
                    out_data  <= cap_data_q;
                    out_par   <= calc_par;
                    out_err   <= (cap_src_q == SRC_B) && (calc_par != cap_par_q);
                    state_q   <= StResp;
                end
                StResp: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

    // Clear wins over a same-cycle erroring accept; the count sticks at all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (resp_acc && out_err && (err_cnt != CntMax)) begin
            err_cnt <= err_cnt + CntOne;
        end
    end

endmodule

// File: tb/tb_parity_arb_ctrl.sv
// Bench for parity_arb_ctrl: directed scenarios followed by random traffic,
// checked against a transaction-level model of grant order, parity and error count.
module tb_parity_arb_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, b_valid, b_par, out_ready, err_clr;
    logic [7:0] a_data, b_data;

    logic       a_ready, b_ready, out_valid, out_src, out_par, out_err;
    logic [7:0] out_data, err_cnt;

    logic       d2_a_ready, d2_b_ready, d2_out_valid, d2_out_src, d2_out_par, d2_out_err;
    logic [7:0] d2_out_data;
    logic [1:0] d2_err_cnt;

    int ntests = 0;
    int nfail  = 0;

    // Model state
    bit         m_last;
    int         m_cnt8, m_cnt2;
    bit         pend_a, pend_b, pend_pb;
    logic [7:0] pend_da, pend_db;

    always #5 clk = ~clk;

    parity_arb_ctrl dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_par(b_par), .b_ready(b_ready),
        .out_valid(out_valid), .out_src(out_src), .out_data(out_data),
        .out_par(out_par), .out_err(out_err), .out_ready(out_ready),
        .err_clr(err_clr), .err_cnt(err_cnt)
    );

    parity_arb_ctrl #(.DATA_W(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(d2_a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_par(b_par), .b_ready(d2_b_ready),
        .out_valid(d2_out_valid), .out_src(d2_out_src), .out_data(d2_out_data),
        .out_par(d2_out_par), .out_err(d2_out_err), .out_ready(out_ready),
        .err_clr(err_clr), .err_cnt(d2_err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic bit xor8(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return bit'(ones % 2);
    endfunction

    // Serve one request from the pending set; entered and left at a negedge with the DUT idle.
    task automatic serve(input int stall, input bit clr);
        bit         g, ep, ee;
        logic [7:0] d;
        bit         p;
        a_valid = pend_a; a_data = pend_da;
        b_valid = pend_b; b_data = pend_db; b_par = pend_pb;
        out_ready = 1'b0; err_clr = 1'b0;
        g = (pend_a && pend_b) ? !m_last : pend_b;
        #1;
        chk("grant_a_ready", a_ready, !g);
        chk("grant_b_ready", b_ready, g);
        cyc();
        m_last = g;
        if (g) begin
            pend_b = 0; b_valid = 0; d = pend_db; p = pend_pb;
            b_data = ~pend_db; b_par = ~pend_pb;
        end else begin
            pend_a = 0; a_valid = 0; d = pend_da; p = 0;
            a_data = ~pend_da;
        end
        ep = xor8(d);
        ee = g && (ep != p);
        #1;
        chk("calc_out_valid", out_valid, 0);
        chk("calc_a_ready", a_ready, 0);
        chk("calc_b_ready", b_ready, 0);
        cyc();
        chk("resp_out_valid", out_valid, 1);
        chk("resp_out_src", out_src, g);
        chk("resp_out_data", out_data, d);
        chk("resp_out_par", out_par, ep);
        chk("resp_out_err", out_err, ee);
        for (int s = 0; s < stall; s++) begin
            cyc();
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_src", out_src, g);
            chk("stall_out_data", out_data, d);
            chk("stall_out_par", out_par, ep);
            chk("stall_out_err", out_err, ee);
            chk("stall_a_ready", a_ready, 0);
            chk("stall_b_ready", b_ready, 0);
        end
        out_ready = 1'b1; err_clr = clr;
        cyc();
        if (clr) begin
            m_cnt8 = 0; m_cnt2 = 0;
        end else if (ee) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        out_ready = 1'b0; err_clr = 1'b0;
        #1;
        chk("acc_out_valid", out_valid, 0);
        chk("err_cnt8", err_cnt, m_cnt8);
        chk("err_cnt2", d2_err_cnt, m_cnt2);
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 1'b1; a_data = 8'h01;
        b_valid = 1'b1; b_data = 8'h55; b_par = 1'b1;
        out_ready = 1'b1; err_clr = 1'b0;
        m_last = 1'b1; m_cnt8 = 0; m_cnt2 = 0;
        pend_a = 0; pend_b = 0; pend_pb = 0; pend_da = '0; pend_db = '0;
        cyc();
        cyc();
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_par", out_par, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst = 1'b0;
        out_ready = 1'b0;

        // Contention straight out of reset: A first, then alternation.
        pend_a = 1; pend_da = 8'h01;
        pend_b = 1; pend_db = 8'h55; pend_pb = 1;
        serve(0, 0);
        pend_a = 1; pend_da = 8'h03;
        serve(0, 0);
        serve(0, 0);
        pend_b = 1; pend_db = 8'hDB; pend_pb = 0;
        serve(0, 0);

        // Nothing valid: stays idle.
        a_valid = 0; b_valid = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("idle_out_valid", out_valid, 0);
        end

        // Three-cycle back-pressure with B waiting.
        pend_a = 1; pend_da = 8'hA5;
        pend_b = 1; pend_db = 8'h0F; pend_pb = 1;
        serve(3, 0);
        serve(1, 0);

        // Five erroring B responses saturate the narrow counter.
        for (int i = 0; i < 5; i++) begin
            pend_b = 1; pend_db = 8'h55; pend_pb = 1;
            serve(0, 0);
        end
        chk("sat_err_cnt2", d2_err_cnt, 3);
        pend_b = 1; pend_db = 8'h07; pend_pb = 0;
        serve(0, 1);

        // Reset while in CALC discards the request.
        pend_b = 1; pend_db = 8'h01; pend_pb = 0;
        serve(0, 0);
        a_valid = 0; b_valid = 1; b_data = 8'h55; b_par = 1;
        #1;
        chk("pre_rst_b_ready", b_ready, 1);
        cyc();
        b_valid = 0;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_err_cnt8", err_cnt, 0);
        chk("mid_rst_err_cnt2", d2_err_cnt, 0);
        cyc();
        rst = 1'b0;
        m_last = 1; m_cnt8 = 0; m_cnt2 = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("post_rst_out_valid", out_valid, 0);
        end
        out_ready = 1'b0;
        pend_a = 1; pend_da = 8'hFE;
        pend_b = 1; pend_db = 8'h33; pend_pb = 1;
        serve(0, 0);

        // Random traffic.
        for (int n = 0; n < 60; n++) begin
            if (!pend_a && ($urandom_range(0, 1) == 1)) begin
                pend_a = 1; pend_da = 8'($urandom);
            end
            if (!pend_b && ($urandom_range(0, 1) == 1)) begin
                pend_b = 1; pend_db = 8'($urandom); pend_pb = 1'($urandom);
            end
            if (!pend_a && !pend_b) begin
                pend_b = 1; pend_db = 8'($urandom); pend_pb = 1'($urandom);
            end
            serve(int'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
